// File: rtl/output_token_writer_pkg.sv
// output_token_writer_pkg: shared FSM state encodings and width helper for the output token writer
//   OTW_IDLE..OTW_DONE : 3-bit state encodings
//   log2               : ceiling log2, used for address widths
package output_token_writer_pkg;
    typedef logic [2:0] otw_state_t;
    localparam logic [2:0] OTW_IDLE       = 3'd0;
    localparam logic [2:0] OTW_WAIT_SPACE = 3'd1;
    localparam logic [2:0] OTW_WR_HI      = 3'd2;
    localparam logic [2:0] OTW_WR_LO      = 3'd3;
    localparam logic [2:0] OTW_DONE       = 3'd4;
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/output_token_writer_word_splitter.sv
// output_token_writer_word_splitter: selects the MSW or LSW of a double-width word, 0 when not enabled
//   word   : 2*word_size input word
//   sel_hi : 1 selects the upper half, 0 the lower half
//   en     : output gate; token is 0 when low
//   token  : selected word_size token
module output_token_writer_word_splitter #(
    parameter int word_size = 16
) (
    input  logic [2*word_size-1:0] word,
    input  logic                   sel_hi,
    input  logic                   en,
    output logic [word_size-1:0]   token
);
    always_comb
        token = !en ? '0 : sel_hi ? word[2*word_size-1:word_size] : word[word_size-1:0];
endmodule

// File: rtl/output_token_writer.sv
// output_token_writer: captures result/status words on a strobe and writes them MSW-first as token pairs to two FIFOs
//   clk, rst (async, active-low), rst_instr (sync, active-low soft reset)
//   en_wr_in, result_in, status_in           : capture strobe and double-width words
//   pop_out_fifo_result, pop_out_fifo_status : current FIFO populations (backpressure)
//   wr_out_*, data_out_*                     : FIFO write enables and tokens
//   busy, done_wr, drop_err                  : status to the parent FSM
//   tokens_written                           : token counter, only with OUTPUT_TOKEN_COUNT_EN
module output_token_writer
    import output_token_writer_pkg::*;
#(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rst_instr,
    input  logic                   en_wr_in,
    input  logic [2*word_size-1:0] result_in,
    input  logic [2*word_size-1:0] status_in,
    input  logic [word_size-1:0]   pop_out_fifo_result,
    input  logic [word_size-1:0]   pop_out_fifo_status,
    output logic                   wr_out_result,
    output logic                   wr_out_status,
    output logic [word_size-1:0]   data_out_result,
    output logic [word_size-1:0]   data_out_status,
    output logic                   busy,
    output logic                   done_wr,
    output logic                   drop_err
`ifdef OUTPUT_TOKEN_COUNT_EN
    ,
    output logic [word_size-1:0]   tokens_written
`endif
);
    // A pair needs two free slots; space is checked once because only this block fills the FIFOs.
    localparam logic [word_size-1:0] space_lim = word_size'(buffer_size - 2);
    otw_state_t state, state_nx;
    logic [2*word_size-1:0] res_q, sts_q;
    logic space_ok, wr_phase;
    assign space_ok = (pop_out_fifo_result <= space_lim) && (pop_out_fifo_status <= space_lim);
    always_comb
        state_nx = state == OTW_IDLE       ? (en_wr_in ? OTW_WAIT_SPACE : OTW_IDLE) :
                   state == OTW_WAIT_SPACE ? (space_ok ? OTW_WR_HI : OTW_WAIT_SPACE) :
                   state == OTW_WR_HI      ? OTW_WR_LO :
                   state == OTW_WR_LO      ? OTW_DONE : OTW_IDLE;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= OTW_IDLE;
            res_q    <= '0;
            sts_q    <= '0;
            drop_err <= 1'b0;
        end else if (!rst_instr) begin
            state    <= OTW_IDLE;
            res_q    <= '0;
            sts_q    <= '0;
            drop_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (en_wr_in && state == OTW_IDLE) begin
                res_q <= result_in;
                sts_q <= status_in;
            end
            if (en_wr_in && state != OTW_IDLE) drop_err <= 1'b1;
        end
`ifdef OUTPUT_TOKEN_COUNT_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) tokens_written <= '0;
        else if (!rst_instr) tokens_written <= '0;
        else if (state == OTW_DONE) tokens_written <= tokens_written + word_size'(2);
`endif
    assign wr_phase      = (state == OTW_WR_HI) || (state == OTW_WR_LO);
    assign wr_out_result = wr_phase;
    assign wr_out_status = wr_phase;
    assign busy          = state != OTW_IDLE;
    assign done_wr       = state == OTW_DONE;
    output_token_writer_word_splitter #(.word_size(word_size)) u_split_result (
        .word   (res_q),
        .sel_hi (state == OTW_WR_HI),
        .en     (wr_phase),
        .token  (data_out_result)
    );
    output_token_writer_word_splitter #(.word_size(word_size)) u_split_status (
        .word   (sts_q),
        .sel_hi (state == OTW_WR_HI),
        .en     (wr_phase),
        .token  (data_out_status)
    );
endmodule
